// File: rtl/xaui_pkg.sv
// Shared state encoding for the XAUI lane reset / link-recovery controller.
package xaui_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_TX_RST    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RX_RST    = 3'd2,
    ST_WAIT_SYNC = 3'd3,
    ST_LINK_UP   = 3'd4
  } state_t;

endpackage

// File: rtl/xaui_sat_counter.sv
// Saturating event counter; a clear beats a simultaneous increment.
module xaui_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/xaui_lane_reset_ctrl.sv
// MGT reset sequencer and link-recovery FSM for NUM_LANES XAUI lanes.
// state | meaning: TX_RST hold TX+RX reset | WAIT_LOCK wait CDR lock | RX_RST hold RX reset | WAIT_SYNC wait comma sync | LINK_UP link usable
module xaui_lane_reset_ctrl
  import xaui_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int TX_RESET_CYCLES = 16,
  parameter int RX_RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int SYNC_TIMEOUT    = 65535,
  parameter int TIMER_WIDTH     = 20,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   xaui_reset,
  input  logic [NUM_LANES-1:0]   mgt_rxlock,
  input  logic [NUM_LANES-1:0]   mgt_rxbufferr,
  input  logic [NUM_LANES-1:0]   mgt_syncok,
  input  logic                   count_clear,
  output logic [NUM_LANES-1:0]   mgt_tx_reset,
  output logic [NUM_LANES-1:0]   mgt_rx_reset,
  output logic                   link_up,
  output logic [STATE_WIDTH-1:0] state,
  output logic [CNT_WIDTH-1:0]   retry_count,
  output logic [CNT_WIDTH-1:0]   bufferr_count
);

  localparam logic [TIMER_WIDTH-1:0] TX_LOAD   = TIMER_WIDTH'(TX_RESET_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] LOCK_LOAD = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] RX_LOAD   = TIMER_WIDTH'(RX_RESET_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] SYNC_LOAD = TIMER_WIDTH'(SYNC_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   force_load;
  logic                   retry_inc, bufferr_inc;
  logic                   all_lock, any_bufferr, all_sync, timer_done;

  assign all_lock    = &mgt_rxlock;
  assign any_bufferr = |mgt_rxbufferr;
  assign all_sync    = &mgt_syncok;
  assign timer_done  = (timer_q == '0);

  function automatic logic [TIMER_WIDTH-1:0] load_value(input state_t s);
    case (s)
      ST_TX_RST:    load_value = TX_LOAD;
      ST_WAIT_LOCK: load_value = LOCK_LOAD;
      ST_RX_RST:    load_value = RX_LOAD;
      ST_WAIT_SYNC: load_value = SYNC_LOAD;
      default:      load_value = '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_TX_RST;
      timer_q <= TX_LOAD;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    force_load  = 1'b0;
    retry_inc   = 1'b0;
    bufferr_inc = 1'b0;
    if (xaui_reset) begin
      // soft reset keeps reloading so TX_RST lasts the full length after release
      state_d    = ST_TX_RST;
      force_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_TX_RST: begin
          if (timer_done) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (all_lock) begin
            state_d = ST_RX_RST;
          end else if (timer_done) begin
            state_d   = ST_TX_RST;
            retry_inc = 1'b1;
          end
        end
        ST_RX_RST: begin
          if (timer_done) state_d = ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC: begin
          if (!all_lock) begin
            state_d = ST_WAIT_LOCK;
          end else if (all_sync) begin
            state_d = ST_LINK_UP;
          end else if (timer_done) begin
            state_d   = ST_RX_RST;
            retry_inc = 1'b1;
          end
        end
        ST_LINK_UP: begin
          if (!all_lock) begin
            state_d = ST_WAIT_LOCK;
          end else if (any_bufferr) begin
            state_d     = ST_RX_RST;
            bufferr_inc = 1'b1;
          end else if (!all_sync) begin
            state_d = ST_WAIT_SYNC;
          end
        end
        default: begin
          state_d    = ST_TX_RST;
          force_load = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (force_load || (state_d != state_q)) begin
      timer_d = load_value(state_d);
    end else if (!timer_done) begin
      timer_d = timer_q - TIMER_WIDTH'(1);
    end
  end

  assign mgt_tx_reset = {NUM_LANES{state_q == ST_TX_RST}};
  assign mgt_rx_reset = {NUM_LANES{(state_q == ST_TX_RST) || (state_q == ST_WAIT_LOCK) ||
                                   (state_q == ST_RX_RST)}};
  assign link_up      = (state_q == ST_LINK_UP);
  assign state        = state_q;

  xaui_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_retry_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retry_inc),
    .clr   (count_clear),
    .count (retry_count)
  );

  xaui_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bufferr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bufferr_inc),
    .clr   (count_clear),
    .count (bufferr_count)
  );

endmodule

// File: tb/tb_xaui_lane_reset_ctrl.sv
// Scenario-driven bench for xaui_lane_reset_ctrl with a cycle-level behavioural model.
module tb_xaui_lane_reset_ctrl;

  localparam int NL  = 4;
  localparam int TXC = 16;
  localparam int RXC = 16;
  localparam int LTO = 50;
  localparam int STO = 100;
  localparam int TW  = 20;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, xaui_reset, count_clear;
  logic [NL-1:0] rxlock, rxbufferr, syncok;
  logic [NL-1:0] tx_rst, rx_rst;
  logic          link_up;
  logic [2:0]    state;
  logic [CW-1:0] retry_count, bufferr_count;

  int checks = 0;
  int errors = 0;

  // model: state number, cycles spent in it, and the two counters
  int m_state, m_age, m_retry, m_buf;

  xaui_lane_reset_ctrl #(
    .NUM_LANES(NL), .TX_RESET_CYCLES(TXC), .RX_RESET_CYCLES(RXC),
    .LOCK_TIMEOUT(LTO), .SYNC_TIMEOUT(STO), .TIMER_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .xaui_reset(xaui_reset),
    .mgt_rxlock(rxlock), .mgt_rxbufferr(rxbufferr), .mgt_syncok(syncok),
    .count_clear(count_clear),
    .mgt_tx_reset(tx_rst), .mgt_rx_reset(rx_rst), .link_up(link_up),
    .state(state), .retry_count(retry_count), .bufferr_count(bufferr_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_age = 0; m_retry = 0; m_buf = 0;
  endtask

  function automatic logic [19:0] model_outputs();
    logic [NL-1:0] etx, erx;
    etx = (m_state == 0) ? '1 : '0;
    erx = (m_state <= 2) ? '1 : '0;
    return {3'(m_state), etx, erx, (m_state == 4), 2'(m_retry), 2'(m_buf)};
  endfunction

  // one clock: evaluate the spec rules on the present inputs, then let the edge happen
  task automatic tick();
    int  nxt;
    bit  restart, ir, ib, all_l, all_s, any_b;
    nxt = m_state; restart = 0; ir = 0; ib = 0;
    all_l = (rxlock == '1); all_s = (syncok == '1); any_b = (rxbufferr != '0);
    if (xaui_reset) begin
      nxt = 0; restart = 1;
    end else begin
      case (m_state)
        0: if (m_age + 1 >= TXC) nxt = 1;
        1: if (all_l) nxt = 2; else if (m_age + 1 >= LTO) begin nxt = 0; ir = 1; end
        2: if (m_age + 1 >= RXC) nxt = 3;
        3: if (!all_l) nxt = 1; else if (all_s) nxt = 4;
           else if (m_age + 1 >= STO) begin nxt = 2; ir = 1; end
        default: if (!all_l) nxt = 1; else if (any_b) begin nxt = 2; ib = 1; end
                 else if (!all_s) nxt = 3;
      endcase
    end
    @(posedge clk);
    m_age   = (restart || nxt != m_state) ? 0 : m_age + 1;
    m_state = nxt;
    if (count_clear) m_retry = 0; else if (ir && m_retry < CMAX) m_retry++;
    if (count_clear) m_buf = 0;   else if (ib && m_buf < CMAX) m_buf++;
    #1;
  endtask

  task automatic goto_state(input int target, input string tag);
    for (int i = 0; i < 300 && m_state != target; i++) tick();
    checks++;
    if (state !== 3'(target)) begin
      errors++;
      $display("FAIL %s: reach state got %0d want %0d", tag, state, target);
    end
  endtask

  task automatic test_reset();
    reset = 1; xaui_reset = 0; count_clear = 0;
    rxlock = '0; rxbufferr = '0; syncok = '0;
    repeat (3) @(posedge clk);
    #1; model_reset();
    checks++;
    if ({state, tx_rst, rx_rst, link_up, retry_count, bufferr_count} !== {3'd0, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", {state, tx_rst, rx_rst, link_up, retry_count, bufferr_count},
               {3'd0, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0});
    end
    reset = 0;
    for (int i = 1; i <= TXC; i++) begin
      tick();
      checks++;
      if ({state, tx_rst} !== ((i < TXC) ? {3'd0, 4'hF} : {3'd1, 4'h0})) begin
        errors++;
        $display("FAIL tx_stretch cycle %0d: got %h want %h", i, {state, tx_rst},
                 (i < TXC) ? {3'd0, 4'hF} : {3'd1, 4'h0});
      end
    end
    checks++;
    if ({rx_rst, link_up} !== {4'hF, 1'b0}) begin
      errors++;
      $display("FAIL wait_lock_outputs: got %h want %h", {rx_rst, link_up}, {4'hF, 1'b0});
    end
  endtask

  task automatic test_lock_timeout();
    for (int i = 1; i <= LTO; i++) tick();
    checks++;
    if ({state, retry_count} !== {3'd0, 2'd1}) begin
      errors++;
      $display("FAIL lock_timeout: got %h want %h", {state, retry_count}, {3'd0, 2'd1});
    end
    goto_state(1, "lock_timeout_back");
  endtask

  task automatic test_lock_sync();
    rxlock = 4'hF;
    tick();
    for (int i = 1; i <= RXC; i++) begin
      tick();
      checks++;
      if ({state, rx_rst} !== ((i < RXC) ? {3'd2, 4'hF} : {3'd3, 4'h0})) begin
        errors++;
        $display("FAIL rx_stretch cycle %0d: got %h want %h", i, {state, rx_rst},
                 (i < RXC) ? {3'd2, 4'hF} : {3'd3, 4'h0});
      end
    end
    syncok = 4'hF;
    tick();
    checks++;
    if ({state, link_up, rx_rst, tx_rst} !== {3'd4, 1'b1, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL link_up: got %h want %h", {state, link_up, rx_rst, tx_rst}, {3'd4, 1'b1, 4'h0, 4'h0});
    end
  endtask

  task automatic test_sync_timeout();
    int base, want;
    base = m_retry;
    syncok = 4'h7;
    tick();
    for (int r = 0; r < 4; r++) begin
      for (int i = 1; i <= STO; i++) tick();
      want = (base + r + 1 > CMAX) ? CMAX : base + r + 1;
      checks++;
      if ({state, retry_count} !== {3'd2, 2'(want)}) begin
        errors++;
        $display("FAIL sync_timeout round %0d: got %h want %h", r, {state, retry_count}, {3'd2, 2'(want)});
      end
      for (int i = 1; i <= RXC; i++) tick();
    end
    checks++;
    if (retry_count !== 2'd3) begin
      errors++;
      $display("FAIL retry_saturate: got %0d want 3", retry_count);
    end
    syncok = 4'hF;
    goto_state(4, "sync_recover");
  endtask

  task automatic test_bufferr();
    rxbufferr = 4'h2; tick(); rxbufferr = '0;
    checks++;
    if ({state, link_up, bufferr_count} !== {3'd2, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL bufferr_exit: got %h want %h", {state, link_up, bufferr_count}, {3'd2, 1'b0, 2'd1});
    end
    goto_state(4, "bufferr_recover");
    rxbufferr = 4'h2; count_clear = 1; tick(); rxbufferr = '0; count_clear = 0;
    checks++;
    if ({state, bufferr_count, retry_count} !== {3'd2, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL clear_beats_inc: got %h want %h", {state, bufferr_count, retry_count}, {3'd2, 2'd0, 2'd0});
    end
    goto_state(4, "clear_recover");
    rxbufferr = 4'h8; tick(); rxbufferr = '0;
    goto_state(4, "bufferr2_recover");
  endtask

  task automatic test_lock_loss();
    rxlock = 4'hE; rxbufferr = 4'h1; tick(); rxbufferr = '0;
    checks++;
    if ({state, bufferr_count} !== {3'd1, 2'd1}) begin
      errors++;
      $display("FAIL lock_loss_priority: got %h want %h", {state, bufferr_count}, {3'd1, 2'd1});
    end
    rxlock = 4'hF;
  endtask

  task automatic test_xaui_reset();
    logic [CW-1:0] sr, sb;
    goto_state(2, "to_rx_rst");
    repeat (3) tick();
    sr = retry_count; sb = bufferr_count;
    rxlock = '0;
    xaui_reset = 1;
    for (int i = 0; i < 5; i++) tick();
    xaui_reset = 0;
    for (int i = 1; i <= TXC; i++) begin
      tick();
      checks++;
      if (state !== ((i < TXC) ? 3'd0 : 3'd1)) begin
        errors++;
        $display("FAIL soft_reset_hold cycle %0d: got %0d want %0d", i, state, (i < TXC) ? 0 : 1);
      end
    end
    checks++;
    if ({retry_count, bufferr_count} !== {sr, sb}) begin
      errors++;
      $display("FAIL soft_reset_counters: got %h want %h", {retry_count, bufferr_count}, {sr, sb});
    end
  endtask

  task automatic test_async_reset();
    rxlock = 4'hF; syncok = 4'hF;
    goto_state(4, "to_link_up");
    @(posedge clk); #3;
    reset = 1; #1; model_reset();
    checks++;
    if ({state, tx_rst, rx_rst, link_up, retry_count, bufferr_count} !== {3'd0, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", {state, tx_rst, rx_rst, link_up, retry_count, bufferr_count},
               {3'd0, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0});
    end
    reset = 0;
  endtask

  task automatic test_random();
    logic [19:0] exp;
    for (int n = 0; n < 3000; n++) begin
      rxlock      = ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'hF;
      syncok      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      rxbufferr   = ($urandom_range(0, 63) == 0) ? 4'($urandom) : 4'h0;
      xaui_reset  = ($urandom_range(0, 199) == 0);
      count_clear = ($urandom_range(0, 149) == 0);
      tick();
      exp = model_outputs();
      checks++;
      if ({state, tx_rst, rx_rst, link_up, retry_count, bufferr_count} !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: got %h want %h", n,
                 {state, tx_rst, rx_rst, link_up, retry_count, bufferr_count}, exp);
      end
    end
    xaui_reset = 0; count_clear = 0; rxbufferr = '0;
  endtask

  initial begin
    test_reset();
    test_lock_timeout();
    test_lock_sync();
    test_sync_timeout();
    test_bufferr();
    test_lock_loss();
    test_xaui_reset();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xaui_lane_reset_ctrl.md
Name: xaui_lane_reset_ctrl

Overview:
Parametrised MGT reset and link-recovery controller for XAUI-class PHYs with NUM_LANES lanes, replacing fixed 4-lane, fixed-length reset stretching.
Sequences TX reset, waits for CDR lock, applies RX reset, then waits for lane sync.
Recovers automatically from lock loss, elastic-buffer errors and sync timeouts.
Exports link state and saturating error counters to the PHY wrapper and the register interface.

Parameters:
NUM_LANES, 4, number of MGT lanes (1..8)
TX_RESET_CYCLES, 16, TX reset assertion length in clk cycles (>=1)
RX_RESET_CYCLES, 16, RX reset assertion length in clk cycles (>=1)
LOCK_TIMEOUT, 65535, cycles in WAIT_LOCK before retrying from TX_RST
SYNC_TIMEOUT, 65535, cycles in WAIT_SYNC before retrying from RX_RST
TIMER_WIDTH, 20, timer width; every cycle/timeout parameter must be < 2^TIMER_WIDTH
CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  user clock
reset  in  1  asynchronous, active-high reset
xaui_reset  in  1  synchronous soft reset request, level
mgt_rxlock  in  NUM_LANES  per-lane CDR lock
mgt_rxbufferr  in  NUM_LANES  per-lane RX elastic-buffer error
mgt_syncok  in  NUM_LANES  per-lane comma sync achieved
count_clear  in  1  synchronous clear of both counters
mgt_tx_reset  out  NUM_LANES  TX PCS reset, all bits identical
mgt_rx_reset  out  NUM_LANES  RX PCS reset, all bits identical
link_up  out  1  high only in LINK_UP
state  out  3  current state encoding
retry_count  out  CNT_WIDTH  saturating count of timeout retries
bufferr_count  out  CNT_WIDTH  saturating count of LINK_UP exits caused by buffer error

Behaviour:
- Outputs are Moore: decoded from the registered state and change on the same edge as the state.
- States and encodings: TX_RST=0, WAIT_LOCK=1, RX_RST=2, WAIT_SYNC=3, LINK_UP=4.
- Output decode:
  - mgt_tx_reset = 1 only in TX_RST.
  - mgt_rx_reset = 1 in TX_RST, WAIT_LOCK and RX_RST.
  - link_up = 1 only in LINK_UP.
- Async reset: state=TX_RST, timer=TX_RESET_CYCLES-1, both counters=0. Outputs therefore reset to: tx/rx resets all ones, link_up=0, state=0.
- Timer: loaded on every state entry, decrements each cycle, and the exit condition is timer==0.
  - TX_RST: load TX_RESET_CYCLES-1. Resets held exactly TX_RESET_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: load LOCK_TIMEOUT-1.
    - All mgt_rxlock high → RX_RST.
    - Else timer==0 → TX_RST, retry_count++.
  - RX_RST: load RX_RESET_CYCLES-1. Held exactly RX_RESET_CYCLES cycles, then go to WAIT_SYNC.
  - WAIT_SYNC: load SYNC_TIMEOUT-1.
    - Any rxlock low → WAIT_LOCK.
    - Else all syncok high → LINK_UP.
    - Else timer==0 → RX_RST, retry_count++.
  - LINK_UP, priority order:
    - Any rxlock low → WAIT_LOCK.
    - Else any rxbufferr → RX_RST, bufferr_count++.
    - Else any syncok low → WAIT_SYNC.
- xaui_reset high in any state → TX_RST with the timer reloaded, overriding all other transitions. While held, the block stays in TX_RST, reloading every cycle.
- Counters:
  - Saturate at all-ones.
  - count_clear beats a simultaneous increment: the result is 0.
  - Counters are unaffected by xaui_reset.
- Lane reduction: "all" is AND over NUM_LANES bits, "any" is OR. No per-lane masking.
- Inputs are assumed synchronous to clk; synchronising MGT status is the caller's job.

Decomposition:
- Package xaui_pkg:
  - state encoding constants (3-bit).
  - STATE_WIDTH=3.
- Sub-module xaui_sat_counter(CNT_WIDTH): ports clk, reset, inc, clr, count. Instantiated twice.
- Top-level holds the FSM, the timer and the output decode.

Test Plan:
- Async reset pulse, all inputs 0 → tx/rx reset all ones for 16 cycles after release, then tx_reset=0, state=1, rx_reset still 1.
- Raise rxlock=4'hF while in WAIT_LOCK → rx_reset stays high exactly 16 more cycles; state 2→3. Set syncok=4'hF → state=4, link_up=1, rx_reset=0.
- Sync timeout: use SYNC_TIMEOUT=100 and keep syncok=4'h7 → after 100 cycles in WAIT_SYNC, state=2 and retry_count=1. Repeated with counters at CNT_WIDTH=2 → saturates at 3.
- In LINK_UP, one-cycle mgt_rxbufferr=4'h2 → next edge state=2, link_up=0, bufferr_count=1. Same cycle with count_clear=1 → count=0.
- In LINK_UP, drop rxlock[0] together with bufferr → state=1 (lock loss wins) and bufferr_count unchanged.
- xaui_reset asserted for 5 cycles mid-RX_RST → state=0 for 5+16 cycles; counters unchanged. Async reset asserted mid-LINK_UP → immediate state=0, counters=0.
